// File: rtl/bpsk_pkg.sv
// ============================================================================
// Module      : bpsk_pkg
// Description : Shared FSM state type and sine table generator for the BPSK modulator.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package bpsk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } state_e;

    localparam real c_PI = 3.14159265358979323846;

    // Amplitude is 2^(W-1)-1 so the table is symmetric and its negation always fits.
    function automatic int sine_lut_entry(input int idx, input int samples_per_bit,
                                          input int out_width);
        real amp;
        real v;
        amp = real'((1 << (out_width - 1)) - 1);
        v   = amp * $sin(2.0 * c_PI * real'(idx) / real'(samples_per_bit));
        if (v >= 0.0) begin
            return $rtoi(v + 0.5);
        end
        return -$rtoi(0.5 - v);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bpsk_sine_lut.sv
// ============================================================================
// Module      : bpsk_sine_lut
// Description : Combinational one-period sine ROM, signed OUT_WIDTH samples.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bpsk_sine_lut
    import bpsk_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = 16,
    parameter int OUT_WIDTH       = 12
) (
    input  logic [$clog2(SAMPLES_PER_BIT)-1:0] idx_i,
    output logic signed [OUT_WIDTH-1:0]        sample_o
);

    logic signed [OUT_WIDTH-1:0] w_rom [SAMPLES_PER_BIT];

    for (genvar i = 0; i < SAMPLES_PER_BIT; i++) begin : g_rom
        assign w_rom[i] = OUT_WIDTH'(sine_lut_entry(i, SAMPLES_PER_BIT, OUT_WIDTH));
    end

    assign sample_o = w_rom[idx_i];

endmodule

`default_nettype wire

// File: rtl/bpsk_modulator.sv
// ============================================================================
// Module      : bpsk_modulator
// Description : Drives an upstream PISO and emits one sine period per bit, sign set by the bit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bpsk_modulator
    import bpsk_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = 16,
    parameter int BITS_PER_WORD   = 32,
    parameter int OUT_WIDTH       = 12
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        word_valid,
    input  logic                        serial_bit,
    output logic                        load_strobe,
    output logic                        shift_strobe,
    output logic                        word_ready,
    output logic signed [OUT_WIDTH-1:0] sample,
    output logic                        sample_valid,
    output logic                        busy
);

    localparam int c_SIDX_W = $clog2(SAMPLES_PER_BIT);
    localparam int c_BIDX_W = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;

    localparam logic [c_SIDX_W-1:0] c_SIDX_LAST = c_SIDX_W'(SAMPLES_PER_BIT - 1);
    localparam logic [c_BIDX_W-1:0] c_BIDX_LAST = c_BIDX_W'(BITS_PER_WORD - 1);

    state_e                      state_q;
    logic [c_SIDX_W-1:0]         sample_idx_q;
    logic [c_BIDX_W-1:0]         bit_idx_q;
    logic signed [OUT_WIDTH-1:0] sample_q;
    logic                        sample_valid_q;

    logic signed [OUT_WIDTH-1:0] w_lut;
    logic signed [OUT_WIDTH-1:0] sample_d;
    logic                        w_last_sample;
    logic                        w_last_bit;

    bpsk_sine_lut #(
        .SAMPLES_PER_BIT (SAMPLES_PER_BIT),
        .OUT_WIDTH       (OUT_WIDTH)
    ) u_lut (
        .idx_i    (sample_idx_q),
        .sample_o (w_lut)
    );

    assign sample_d      = serial_bit ? w_lut : -w_lut;
    assign w_last_sample = (sample_idx_q == c_SIDX_LAST);
    assign w_last_bit    = (bit_idx_q == c_BIDX_LAST);

    // Strobes are decoded from the current state so a frozen (enable=0) cycle never strobes.
    assign load_strobe  = (state_q == LOAD) && enable;
    assign word_ready   = (state_q == LOAD) && enable;
    assign shift_strobe = (state_q == RUN) && enable && w_last_sample;
    assign busy         = (state_q != IDLE);
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            sample_idx_q   <= '0;
            bit_idx_q      <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else if (enable) begin
            case (state_q)
                IDLE: begin
                    sample_q       <= '0;
                    sample_valid_q <= 1'b0;
                    if (word_valid) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    sample_q       <= '0;
                    sample_valid_q <= 1'b0;
                    state_q        <= SETTLE;
                end
                SETTLE: begin
                    sample_q       <= '0;
                    sample_valid_q <= 1'b0;
                    sample_idx_q   <= '0;
                    bit_idx_q      <= '0;
                    state_q        <= RUN;
                end
                RUN: begin
                    sample_q       <= sample_d;
                    sample_valid_q <= 1'b1;
                    if (w_last_sample) begin
                        sample_idx_q <= '0;
                        if (w_last_bit) begin
                            bit_idx_q <= '0;
                            state_q   <= word_valid ? LOAD : IDLE;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        sample_idx_q <= sample_idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q        <= IDLE;
                    sample_q       <= '0;
                    sample_valid_q <= 1'b0;
                end
            endcase
        end else begin
            sample_valid_q <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bpsk_modulator.sv
// ============================================================================
// Module      : tb_bpsk_modulator
// Description : Self-checking bench with an upstream PISO and a sine reference model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_bpsk_modulator;

    localparam int SPB  = 4;
    localparam int BPW  = 4;
    localparam int OW   = 12;
    localparam int AMP  = 2047;
    localparam int LOGN = 1024;
    localparam int F_LS = 0, F_SS = 1, F_WR = 2, F_VAL = 3, F_SMP = 4, F_BUSY = 5, F_EN = 6;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic word_valid;
    logic serial_bit;
    logic load_strobe;
    logic shift_strobe;
    logic word_ready;
    logic signed [OW-1:0] sample;
    logic sample_valid;
    logic busy;

    logic [BPW-1:0] word_in;
    logic [BPW-1:0] piso_q;

    int lg [7][LOGN];
    int n_log;
    int n_pass;
    int n_total;

    always #5 clk = ~clk;

    bpsk_modulator #(
        .SAMPLES_PER_BIT (SPB),
        .BITS_PER_WORD   (BPW),
        .OUT_WIDTH       (OW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .word_valid   (word_valid),
        .serial_bit   (serial_bit),
        .load_strobe  (load_strobe),
        .shift_strobe (shift_strobe),
        .word_ready   (word_ready),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy)
    );

    // Upstream PISO: MSB first.
    always @(posedge clk) begin
        if (reset)             piso_q <= '0;
        else if (load_strobe)  piso_q <= word_in;
        else if (shift_strobe) piso_q <= {piso_q[BPW-2:0], 1'b0};
    end
    assign serial_bit = piso_q[BPW-1];

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One cycle: observe at the falling edge, then return just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (n_log < LOGN) begin
            lg[F_LS][n_log]   = int'(load_strobe);
            lg[F_SS][n_log]   = int'(shift_strobe);
            lg[F_WR][n_log]   = int'(word_ready);
            lg[F_VAL][n_log]  = int'(sample_valid);
            lg[F_SMP][n_log]  = int'(sample);
            lg[F_BUSY][n_log] = int'(busy);
            lg[F_EN][n_log]   = int'(enable);
            n_log++;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_sample(input int b, input int i);
        real v;
        int  r;
        v = AMP * $sin(2.0 * 3.14159265358979323846 * i / SPB);
        r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        return (b != 0) ? r : -r;
    endfunction

    function automatic int count(input int f, input int val, input int from, input int to);
        int n = 0;
        for (int k = from; k < to; k++) if (lg[f][k] == val) n++;
        return n;
    endfunction

    function automatic int find(input int f, input int from);
        for (int k = from; k < n_log; k++) if (lg[f][k] != 0) return k;
        return -1;
    endfunction

    function automatic int nth_valid(input int n);
        int seen = 0;
        for (int k = 0; k < n_log; k++) begin
            if (lg[F_VAL][k] != 0) begin
                seen++;
                if (seen == n) return k;
            end
        end
        return -1;
    endfunction

    task automatic check_stream(input string tag, input int words[$]);
        int exp_q[$];
        int got_q[$];
        foreach (words[w])
            for (int b = BPW - 1; b >= 0; b--)
                for (int i = 0; i < SPB; i++)
                    exp_q.push_back(ref_sample((words[w] >> b) & 1, i));
        for (int k = 0; k < n_log; k++)
            if (lg[F_VAL][k] != 0) got_q.push_back(lg[F_SMP][k]);
        chk({tag, ".count"}, got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            chk($sformatf("%s.s%0d", tag, k), (k < got_q.size()) ? got_q[k] : -99999, exp_q[k]);
    endtask

    task automatic wait_load(input string tag, output int l);
        l = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (lg[F_LS][n_log-1] != 0) begin
                l = n_log - 1;
                return;
            end
        end
        chk({tag, ".timeout"}, 0, 1);
    endtask

    initial begin
        int l, l1, l2, nwr, w0, w1, wc, we, wf, b0, gap, viol;
        int pend[$];
        int sent[$];

        n_pass  = 0;
        n_total = 0;
        n_log   = 0;

        // Reset wins over enable and word_valid.
        reset = 1'b1; enable = 1'b1; word_valid = 1'b1; word_in = '0;
        repeat (3) tick();
        chk("rst.busy",   lg[F_BUSY][2], 0);
        chk("rst.sample", lg[F_SMP][2],  0);
        chk("rst.valid",  lg[F_VAL][2],  0);
        chk("rst.load",   lg[F_LS][2],   0);
        chk("rst.shift",  lg[F_SS][2],   0);
        chk("rst.ready",  lg[F_WR][2],   0);
        reset = 1'b0; word_valid = 1'b0;
        repeat (2) tick();

        // Single word 1010, word_valid for one cycle only.
        n_log = 0;
        word_in = 4'b1010; word_valid = 1'b1;
        tick();
        word_valid = 1'b0;
        repeat (21) tick();
        chk("A.load_c1",  lg[F_LS][1], 1);
        chk("A.ready_c1", lg[F_WR][1], 1);
        chk("A.loads",    count(F_LS, 1, 0, n_log), 1);
        chk("A.readies",  count(F_WR, 1, 0, n_log), 1);
        chk("A.first_valid", find(F_VAL, 0), 4);
        for (int c = 0; c < 22; c++)
            chk($sformatf("A.shift_c%0d", c), lg[F_SS][c],
                int'(c >= 6 && c <= 18 && (c - 6) % 4 == 0));
        check_stream("A", '{10});
        chk("A.busy_end",   lg[F_BUSY][19], 0);
        chk("A.sample_end", lg[F_SMP][20],  0);
        chk("A.valid_end",  lg[F_VAL][20],  0);

        // Two back-to-back words with word_valid held high.
        n_log = 0;
        w0 = int'($urandom_range(0, 15)); w1 = int'($urandom_range(0, 15));
        word_in = BPW'(w0); word_valid = 1'b1; nwr = 0;
        repeat (45) begin
            tick();
            if (lg[F_WR][n_log-1] != 0) begin
                nwr++;
                if (nwr == 1) word_in = BPW'(w1);
                else word_valid = 1'b0;
            end
        end
        l1 = find(F_LS, 0);
        l2 = find(F_LS, l1 + 1);
        chk("B.readies", count(F_WR, 1, 0, n_log), 2);
        chk("B.load_spacing", l2 - l1, SPB * BPW + 2);
        chk("B.shift_before_load2", (l2 > 0) ? lg[F_SS][l2-1] : -1, 1);
        chk("B.gap", nth_valid(17) - nth_valid(16) - 1, 2);
        check_stream("B", '{w0, w1});

        // Enable low for three cycles while sample_idx=2.
        n_log = 0;
        wc = int'($urandom_range(0, 15));
        word_in = BPW'(wc); word_valid = 1'b1;
        wait_load("C.load", l);
        word_valid = 1'b0;
        repeat (3) tick();
        enable = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        repeat (18) tick();
        b0 = (wc >> 3) & 1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("C.hold_valid%0d", k),  lg[F_VAL][l+5+k], 0);
            chk($sformatf("C.hold_sample%0d", k), lg[F_SMP][l+5+k], ref_sample(b0, 1));
        end
        chk("C.resume_valid",  lg[F_VAL][l+8], 1);
        chk("C.resume_sample", lg[F_SMP][l+8], ref_sample(b0, 2));
        check_stream("C", '{wc});

        // Reset during bit_idx=2 abandons the word.
        n_log = 0;
        we = int'($urandom_range(0, 15));
        word_in = BPW'(we); word_valid = 1'b1;
        wait_load("E.load", l);
        word_valid = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("E.busy",   lg[F_BUSY][l+12], 0);
        chk("E.sample", lg[F_SMP][l+12],  0);
        chk("E.valid",  lg[F_VAL][l+12],  0);
        chk("E.strobes", lg[F_LS][l+12] + lg[F_SS][l+12] + lg[F_WR][l+12], 0);
        repeat (20) tick();
        chk("E.no_ready", count(F_WR, 1, l + 1, n_log), 0);
        chk("E.stays_idle", count(F_BUSY, 1, l + 12, n_log), 0);
        chk("E.no_valid", count(F_VAL, 1, l + 12, n_log), 0);
        n_log = 0;
        wf = int'($urandom_range(0, 15));
        word_in = BPW'(wf); word_valid = 1'b1;
        wait_load("E.fresh_load", l);
        word_valid = 1'b0;
        repeat (20) tick();
        chk("E.fresh_ready", count(F_WR, 1, 0, n_log), 1);
        check_stream("E.fresh", '{wf});

        // Random words, random gaps, random enable stalls.
        n_log = 0;
        for (int k = 0; k < 6; k++) pend.push_back(int'($urandom_range(0, 15)));
        sent = pend;
        gap = 0;
        for (int k = 0; k < 600; k++) begin
            enable     = ($urandom_range(0, 4) != 0);
            word_valid = (pend.size() > 0) && (gap == 0);
            if (pend.size() > 0) word_in = BPW'(pend[0]);
            tick();
            if (gap > 0) gap--;
            if (lg[F_WR][n_log-1] != 0) begin
                void'(pend.pop_front());
                gap = int'($urandom_range(0, 3));
            end
            if (pend.size() == 0 && lg[F_BUSY][n_log-1] == 0 && lg[F_VAL][n_log-1] == 0) break;
        end
        enable = 1'b1; word_valid = 1'b0;
        chk("D.all_sent", pend.size(), 0);
        chk("D.readies", count(F_WR, 1, 0, n_log), 6);
        check_stream("D", sent);
        viol = 0;
        for (int k = 0; k < n_log; k++) begin
            if (lg[F_EN][k] == 0 && (lg[F_LS][k] + lg[F_SS][k] + lg[F_WR][k]) != 0) viol++;
            if (k > 0 && lg[F_EN][k-1] == 0 && lg[F_VAL][k] != 0) viol++;
        end
        chk("D.enable_gating", viol, 0);
        viol = 0;
        for (int k = 0; k < n_log; k++)
            if (lg[F_SMP][k] > AMP || lg[F_SMP][k] < -AMP) viol++;
        chk("D.range", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
